// File: rtl/axi_operand_loader.sv
// axi_operand_loader: AXI read-burst master. It fetches one operand tile of
// NUM_WORDS x 32-bit words into a flattened register buffer that feeds the
// systolic array. Addresses are in 32-bit word units.
//
// Ports:
//   clk, rst          clock and synchronous active-high reset
//   start, base_addr  load request (taken only when idle) and burst start address
//   m_axi_ar*         AXI read-address channel (master side)
//   m_axi_r*          AXI read-data channel (master side)
//   a_out_flat        loaded tile; word i sits at [i*32 +: 32]
//   done, error       one-cycle completion pulse; sticky error, cleared on start
//   debug_state       current FSM state
//   debug_word_count  current beat index
module axi_operand_loader #(
   parameter int unsigned NUM_WORDS = 64,
   parameter int unsigned DATA_W    = 32,
   parameter int unsigned ADDR_W    = 12,
   parameter int unsigned CNT_W     = 6
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          start,
   input  logic [ADDR_W-1:0]             base_addr,
   output logic [ADDR_W-1:0]             m_axi_araddr,
   output logic [1:0]                    m_axi_arburst,
   output logic [3:0]                    m_axi_arcache,
   output logic [7:0]                    m_axi_arlen,
   output logic                          m_axi_arlock,
   output logic [2:0]                    m_axi_arprot,
   output logic [2:0]                    m_axi_arsize,
   output logic                          m_axi_arvalid,
   input  logic                          m_axi_arready,
   input  logic [DATA_W-1:0]             m_axi_rdata,
   input  logic [1:0]                    m_axi_rresp,
   input  logic                          m_axi_rlast,
   input  logic                          m_axi_rvalid,
   output logic                          m_axi_rready,
   output logic [NUM_WORDS*DATA_W-1:0]   a_out_flat,
   output logic                          done,
   output logic                          error,
   output logic [1:0]                    debug_state,
   output logic [CNT_W-1:0]              debug_word_count
);

   localparam int unsigned TILE_W = NUM_WORDS * DATA_W;
   localparam logic [7:0]       ARLEN_VAL = 8'(NUM_WORDS - 1);
   localparam logic [CNT_W-1:0] LAST_IDX  = CNT_W'(NUM_WORDS - 1);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_AR   = 2'd1,
      S_R    = 2'd2,
      S_DONE = 2'd3
   } state_t;

   state_t              state_q,   state_d;
   logic [ADDR_W-1:0]   araddr_q,  araddr_d;
   logic [1:0]          arburst_q, arburst_d;
   logic [3:0]          arcache_q, arcache_d;
   logic [7:0]          arlen_q,   arlen_d;
   logic                arlock_q,  arlock_d;
   logic [2:0]          arprot_q,  arprot_d;
   logic [2:0]          arsize_q,  arsize_d;
   logic                arvalid_q, arvalid_d;
   logic                rready_q,  rready_d;
   logic                done_q,    done_d;
   logic                error_q,   error_d;
   logic [CNT_W-1:0]    count_q,   count_d;
   logic [TILE_W-1:0]   tile_q;
   logic                beat_we_c;

   // Only SLVERR/DECERR matter; the low response bit (EXOKAY) is ignored.
   logic                rresp_lsb_unused_c;
   assign rresp_lsb_unused_c = m_axi_rresp[0];

   // Next-state and registered-output logic.
   always_comb begin
      state_d   = state_q;
      araddr_d  = araddr_q;
      arburst_d = arburst_q;
      arcache_d = arcache_q;
      arlen_d   = arlen_q;
      arlock_d  = arlock_q;
      arprot_d  = arprot_q;
      arsize_d  = arsize_q;
      arvalid_d = arvalid_q;
      rready_d  = rready_q;
      done_d    = 1'b0;
      error_d   = error_q;
      count_d   = count_q;
      beat_we_c = 1'b0;

      case (state_q)
         S_IDLE: begin
            if (start) begin
               araddr_d  = base_addr;
               arburst_d = 2'b01;
               arcache_d = 4'b0011;
               arlen_d   = ARLEN_VAL;
               arsize_d  = 3'b010;
               arlock_d  = 1'b0;
               arprot_d  = 3'b000;
               arvalid_d = 1'b1;
               error_d   = 1'b0;
               count_d   = '0;
               state_d   = S_AR;
            end
         end
         S_AR: begin
            if (arvalid_q && m_axi_arready) begin
               arvalid_d = 1'b0;
               rready_d  = 1'b1;
               state_d   = S_R;
            end
         end
         S_R: begin
            if (m_axi_rvalid && rready_q) begin
               beat_we_c = 1'b1;
               error_d   = error_q | m_axi_rresp[1];
               if (count_q == LAST_IDX) begin
                  // Final word: rlast must coincide with it.
                  rready_d = 1'b0;
                  done_d   = 1'b1;
                  state_d  = S_DONE;
                  if (!m_axi_rlast) error_d = 1'b1;
               end else if (m_axi_rlast) begin
                  // Burst ended short: keep what arrived, flag it.
                  error_d  = 1'b1;
                  rready_d = 1'b0;
                  done_d   = 1'b1;
                  state_d  = S_DONE;
               end else begin
                  count_d = count_q + CNT_W'(1);
               end
            end
         end
         S_DONE: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // Control and AXI attribute registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= S_IDLE;
         araddr_q  <= '0;
         arburst_q <= '0;
         arcache_q <= '0;
         arlen_q   <= '0;
         arlock_q  <= 1'b0;
         arprot_q  <= '0;
         arsize_q  <= '0;
         arvalid_q <= 1'b0;
         rready_q  <= 1'b0;
         done_q    <= 1'b0;
         error_q   <= 1'b0;
         count_q   <= '0;
      end else begin
         state_q   <= state_d;
         araddr_q  <= araddr_d;
         arburst_q <= arburst_d;
         arcache_q <= arcache_d;
         arlen_q   <= arlen_d;
         arlock_q  <= arlock_d;
         arprot_q  <= arprot_d;
         arsize_q  <= arsize_d;
         arvalid_q <= arvalid_d;
         rready_q  <= rready_d;
         done_q    <= done_d;
         error_q   <= error_d;
         count_q   <= count_d;
      end
   end

   // Tile buffer: one slot written per accepted beat, otherwise held.
   always_ff @(posedge clk) begin
      if (rst) begin
         tile_q <= '0;
      end else if (beat_we_c) begin
         tile_q[32'(count_q) * DATA_W +: DATA_W] <= m_axi_rdata;
      end
   end

   assign m_axi_araddr     = araddr_q;
   assign m_axi_arburst    = arburst_q;
   assign m_axi_arcache    = arcache_q;
   assign m_axi_arlen      = arlen_q;
   assign m_axi_arlock     = arlock_q;
   assign m_axi_arprot     = arprot_q;
   assign m_axi_arsize     = arsize_q;
   assign m_axi_arvalid    = arvalid_q;
   assign m_axi_rready     = rready_q;
   assign a_out_flat       = tile_q;
   assign done             = done_q;
   assign error            = error_q;
   assign debug_state      = state_q;
   assign debug_word_count = count_q;

endmodule

// File: tb/tb_axi_operand_loader.sv
// Self-checking bench for axi_operand_loader: table of burst scenarios driven
// by a small AXI slave, plus hand sequences for reset and start corner cases.
module tb_axi_operand_loader;

   localparam int NW = 64;
   localparam int DW = 32;
   localparam int AW = 12;
   localparam int CW = 6;

   logic               clk = 1'b0;
   logic               rst;
   logic               start;
   logic [AW-1:0]      base_addr;
   logic [AW-1:0]      m_axi_araddr;
   logic [1:0]         m_axi_arburst;
   logic [3:0]         m_axi_arcache;
   logic [7:0]         m_axi_arlen;
   logic               m_axi_arlock;
   logic [2:0]         m_axi_arprot;
   logic [2:0]         m_axi_arsize;
   logic               m_axi_arvalid;
   logic               m_axi_arready;
   logic [DW-1:0]      m_axi_rdata;
   logic [1:0]         m_axi_rresp;
   logic               m_axi_rlast;
   logic               m_axi_rvalid;
   logic               m_axi_rready;
   logic [NW*DW-1:0]   a_out_flat;
   logic               done;
   logic               error;
   logic [1:0]         debug_state;
   logic [CW-1:0]      debug_word_count;

   axi_operand_loader #(.NUM_WORDS(NW), .DATA_W(DW), .ADDR_W(AW), .CNT_W(CW)) dut (
      .clk              (clk),
      .rst              (rst),
      .start            (start),
      .base_addr        (base_addr),
      .m_axi_araddr     (m_axi_araddr),
      .m_axi_arburst    (m_axi_arburst),
      .m_axi_arcache    (m_axi_arcache),
      .m_axi_arlen      (m_axi_arlen),
      .m_axi_arlock     (m_axi_arlock),
      .m_axi_arprot     (m_axi_arprot),
      .m_axi_arsize     (m_axi_arsize),
      .m_axi_arvalid    (m_axi_arvalid),
      .m_axi_arready    (m_axi_arready),
      .m_axi_rdata      (m_axi_rdata),
      .m_axi_rresp      (m_axi_rresp),
      .m_axi_rlast      (m_axi_rlast),
      .m_axi_rvalid     (m_axi_rvalid),
      .m_axi_rready     (m_axi_rready),
      .a_out_flat       (a_out_flat),
      .done             (done),
      .error            (error),
      .debug_state      (debug_state),
      .debug_word_count (debug_word_count)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [AW-1:0] base;
      int            ar_wait;    // cycles arready is held low
      int            rv_pct;     // rvalid probability, percent
      int            last_beat;  // beat carrying rlast (-1: never)
      int            err_beat;   // beat carrying err_resp (-1: none)
      logic [1:0]    err_resp;
      bit            rnd;        // random data, else 0xA5000000+i
      bit            exp_err;    // expected error flag after the burst
   } vec_t;

   vec_t          vecs [9];
   int            errors = 0;
   int            checks = 0;
   logic [DW-1:0] tile_m [NW];   // expected tile contents

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
      end
   endtask

   task automatic chk_tile(input string tag);
      for (int i = 0; i < NW; i++)
         chk($sformatf("%s word%0d", tag, i), a_out_flat[i*DW +: DW], tile_m[i]);
   endtask

   task automatic chk_reset_vals(input string tag);
      chk({tag, " tile zero"}, 32'(a_out_flat == '0), 32'd1);
      chk({tag, " arvalid"},  32'(m_axi_arvalid), 0);
      chk({tag, " araddr"},   32'(m_axi_araddr), 0);
      chk({tag, " arlen"},    32'(m_axi_arlen), 0);
      chk({tag, " arburst"},  32'(m_axi_arburst), 0);
      chk({tag, " arcache"},  32'(m_axi_arcache), 0);
      chk({tag, " arsize"},   32'(m_axi_arsize), 0);
      chk({tag, " arlock"},   32'(m_axi_arlock), 0);
      chk({tag, " arprot"},   32'(m_axi_arprot), 0);
      chk({tag, " rready"},   32'(m_axi_rready), 0);
      chk({tag, " done"},     32'(done), 0);
      chk({tag, " error"},    32'(error), 0);
      chk({tag, " state"},    32'(debug_state), 0);
      chk({tag, " count"},    32'(debug_word_count), 0);
   endtask

   // Runs one complete burst acting as the AXI slave and checks the result.
   task automatic run_vec(input int idx, input vec_t v);
      int    term;
      int    b;
      int    cycles;
      bit    acc;
      string t;
      t    = $sformatf("v%0d", idx);
      term = (v.last_beat >= 0 && v.last_beat < NW - 1) ? v.last_beat : NW - 1;

      start     = 1'b1;
      base_addr = v.base;
      step();
      start     = 1'b0;
      base_addr = AW'($urandom);
      chk({t, " arvalid rise"}, 32'(m_axi_arvalid), 1);
      chk({t, " araddr"},  32'(m_axi_araddr), 32'(v.base));
      chk({t, " arlen"},   32'(m_axi_arlen), NW - 1);
      chk({t, " arsize"},  32'(m_axi_arsize), 2);
      chk({t, " arburst"}, 32'(m_axi_arburst), 1);
      chk({t, " arcache"}, 32'(m_axi_arcache), 3);
      chk({t, " arlock"},  32'(m_axi_arlock), 0);
      chk({t, " arprot"},  32'(m_axi_arprot), 0);
      chk({t, " error cleared"}, 32'(error), 0);
      chk({t, " rready pre-ar"}, 32'(m_axi_rready), 0);

      for (int w = 0; w < v.ar_wait; w++) begin
         m_axi_arready = 1'b0;
         step();
         chk({t, " ar hold valid"},  32'(m_axi_arvalid), 1);
         chk({t, " ar hold addr"},   32'(m_axi_araddr), 32'(v.base));
         chk({t, " ar hold rready"}, 32'(m_axi_rready), 0);
      end
      m_axi_arready = 1'b1;
      step();
      m_axi_arready = 1'b0;
      chk({t, " arvalid drop"}, 32'(m_axi_arvalid), 0);
      chk({t, " rready up"},    32'(m_axi_rready), 1);

      b      = 0;
      cycles = 0;
      forever begin
         chk({t, " beat index"}, 32'(debug_word_count), 32'(b));
         acc = ($urandom_range(0, 99) < 32'(v.rv_pct));
         m_axi_rvalid = acc;
         start        = 1'($urandom_range(0, 3) == 0);
         if (acc) begin
            m_axi_rdata = v.rnd ? $urandom : 32'hA500_0000 + 32'(b);
            m_axi_rresp = (b == v.err_beat) ? v.err_resp : 2'b00;
            m_axi_rlast = (b == v.last_beat);
            tile_m[b]   = m_axi_rdata;
         end else begin
            m_axi_rdata = $urandom;
            m_axi_rresp = 2'($urandom);
            m_axi_rlast = 1'($urandom);
         end
         step();
         cycles++;
         chk({t, " no ar in r"}, 32'(m_axi_arvalid), 0);
         if (acc) begin
            if (b == term) break;
            b++;
         end
         if (cycles > 3000) begin
            chk({t, " r phase timeout"}, 1, 0);
            break;
         end
      end
      m_axi_rvalid = 1'b0;
      m_axi_rlast  = 1'b0;
      m_axi_rresp  = 2'b00;
      start        = 1'b0;

      chk({t, " done"},       32'(done), 1);
      chk({t, " error"},      32'(error), 32'(v.exp_err));
      chk({t, " rready off"}, 32'(m_axi_rready), 0);
      chk({t, " state done"}, 32'(debug_state), 3);
      if (v.ar_wait == 0 && v.rv_pct == 100)
         chk({t, " done latency"}, 32'(cycles + 1), NW + 1);
      chk_tile(t);

      step();
      chk({t, " done pulse end"}, 32'(done), 0);
      chk({t, " back idle"},      32'(debug_state), 0);
      chk({t, " error sticky"},   32'(error), 32'(v.exp_err));

      // Idle-time R traffic must not disturb the tile.
      for (int k = 0; k < 3; k++) begin
         m_axi_rvalid = 1'($urandom);
         m_axi_rdata  = $urandom;
         m_axi_rlast  = 1'($urandom);
         step();
      end
      m_axi_rvalid = 1'b0;
      m_axi_rlast  = 1'b0;
      chk_tile({t, " idle"});
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got timeout, want completion");
      $fatal(1, "watchdog");
   end

   initial begin
      //              base     arw rv%  last err  resp   rnd exp_err
      vecs[0] = '{12'h040, 0, 100, 63, -1, 2'b00, 0, 0};
      vecs[1] = '{12'h123, 5, 100, 63, -1, 2'b00, 1, 0};
      vecs[2] = '{12'h7F0, 0,  50, 63, -1, 2'b00, 1, 0};
      vecs[3] = '{12'h200, 2,  70, 63, 10, 2'b10, 1, 1};
      vecs[4] = '{12'h300, 0, 100, 63, -1, 2'b00, 1, 0};
      vecs[5] = '{12'h010, 0,  60,  5, -1, 2'b00, 1, 1};
      vecs[6] = '{12'hABC, 1, 100, -1, -1, 2'b00, 1, 1};
      vecs[7] = '{12'h001, 3,  40, 63, 20, 2'b11, 1, 1};
      vecs[8] = '{12'h0AA, 0, 100, 63,  7, 2'b01, 1, 0};

      for (int i = 0; i < NW; i++) tile_m[i] = '0;
      rst           = 1'b1;
      start         = 1'b0;
      base_addr     = '0;
      m_axi_arready = 1'b0;
      m_axi_rdata   = '0;
      m_axi_rresp   = 2'b00;
      m_axi_rlast   = 1'b0;
      m_axi_rvalid  = 1'b0;
      step();
      step();
      chk_reset_vals("reset");
      rst = 1'b0;
      step();

      for (int i = 0; i < 9; i++) run_vec(i, vecs[i]);

      // Reset on beat 30 aborts the burst.
      start     = 1'b1;
      base_addr = 12'h155;
      step();
      start         = 1'b0;
      m_axi_arready = 1'b1;
      step();
      m_axi_arready = 1'b0;
      for (int b = 0; b < 30; b++) begin
         m_axi_rvalid = 1'b1;
         m_axi_rdata  = $urandom;
         step();
      end
      chk("abort beat index", 32'(debug_word_count), 30);
      m_axi_rvalid = 1'b1;
      m_axi_rdata  = $urandom;
      rst          = 1'b1;
      step();
      rst          = 1'b0;
      m_axi_rvalid = 1'b0;
      chk_reset_vals("abort");
      for (int i = 0; i < NW; i++) tile_m[i] = '0;

      // start held high re-arms from idle straight after done.
      start         = 1'b1;
      base_addr     = 12'h2A0;
      m_axi_arready = 1'b1;
      step();
      step();
      m_axi_arready = 1'b0;
      for (int b = 0; b < NW; b++) begin
         m_axi_rvalid = 1'b1;
         m_axi_rdata  = $urandom;
         m_axi_rlast  = (b == NW - 1);
         tile_m[b]    = m_axi_rdata;
         step();
      end
      m_axi_rvalid = 1'b0;
      m_axi_rlast  = 1'b0;
      chk("held done", 32'(done), 1);
      chk("held error", 32'(error), 0);
      chk_tile("held");
      step();
      chk("held idle state", 32'(debug_state), 0);
      chk("held idle arvalid", 32'(m_axi_arvalid), 0);
      step();
      chk("held rearm arvalid", 32'(m_axi_arvalid), 1);
      chk("held rearm araddr", 32'(m_axi_araddr), 32'h2A0);
      chk("held rearm state", 32'(debug_state), 1);
      chk_tile("held rearm");
      start = 1'b0;
      rst   = 1'b1;
      step();
      rst   = 1'b0;
      chk_reset_vals("final");

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
